// File: rtl/hit_receiver_pkg.sv
// Shared game constants and types used by the bullet receive path.
package hit_receiver_pkg;

   localparam int GAME_X_W      = 11;
   localparam int GAME_Y_W      = 10;
   localparam int HP_W          = 7;

   localparam int BULLET_STEP_X = 11;
   localparam int MAX_HP        = 100;
   localparam int DAMAGE        = 10;
   localparam int HIT_W         = 32;
   localparam int HIT_H         = 64;
   localparam int SCREEN_W      = 640;

   typedef struct packed {
      logic                valid;
      logic                dir;
      logic [GAME_X_W-1:0] x;
      logic [GAME_Y_W-1:0] y;
   } bullet_t;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      CHECK,
      KO
   } state_t;

endpackage

// File: rtl/hit_receiver_bullet_slot.sv
// One in-flight bullet: load, per-frame horizontal step with screen-exit
// detection, and a combinational hitbox test against the target corner.
module bullet_slot
   import hit_receiver_pkg::*;
#(
   parameter int X_W = GAME_X_W,
   parameter int Y_W = GAME_Y_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [X_W-1:0] load_x,
   input  logic [Y_W-1:0] load_y,
   input  logic           load_dir,
   input  logic           step,
   input  logic           clear,
   input  logic [X_W-1:0] tgt_x,
   input  logic [Y_W-1:0] tgt_y,
   output bullet_t        blt,
   output logic           hit
);

   localparam logic signed [X_W:0] STEP_S = (X_W+1)'(BULLET_STEP_X);
   localparam logic signed [X_W:0] X_MAX  = (X_W+1)'(SCREEN_W - 1);

   logic signed [X_W:0] x_s;
   logic signed [X_W:0] moved;
   logic                off_screen;
   logic                in_x;
   logic                in_y;

   // One extra signed bit lets a leftward step below zero show up as negative.
   assign x_s        = signed'({1'b0, blt.x});
   assign moved      = blt.dir ? (x_s - STEP_S) : (x_s + STEP_S);
   assign off_screen = moved[X_W] || (moved > X_MAX);

   assign in_x = ({1'b0, blt.x} >= {1'b0, tgt_x}) &&
                 ({1'b0, blt.x} <  ({1'b0, tgt_x} + (X_W+1)'(HIT_W)));
   assign in_y = ({1'b0, blt.y} >= {1'b0, tgt_y}) &&
                 ({1'b0, blt.y} <  ({1'b0, tgt_y} + (Y_W+1)'(HIT_H)));
   assign hit  = blt.valid && in_x && in_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blt <= '0;
      end else if (clear) begin
         blt.valid <= 1'b0;
      end else if (load) begin
         blt.valid <= 1'b1;
         blt.dir   <= load_dir;
         blt.x     <= load_x;
         blt.y     <= load_y;
      end else if (step && blt.valid) begin
         if (off_screen) begin
            blt.valid <= 1'b0;
         end else begin
            blt.x <= moved[X_W-1:0];
         end
      end
   end

endmodule

// File: rtl/hit_receiver.sv
// Target-side bullet receiver: accepts bullets, steps them each frame,
// applies hit damage to HP and reports KO.
module hit_receiver
   import hit_receiver_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int X_W   = 11,
   parameter int Y_W   = 10
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_frame,
   input  logic               i_round_start,
   input  logic               i_fire_valid,
   output logic               o_fire_ready,
   input  logic [X_W-1:0]     i_fire_x,
   input  logic [Y_W-1:0]     i_fire_y,
   input  logic               i_fire_dir,
   input  logic [X_W-1:0]     i_tgt_x,
   input  logic [Y_W-1:0]     i_tgt_y,
   output logic [HP_W-1:0]    o_hp,
   output logic               o_hit,
   output logic               o_ko,
   output logic [SLOTS-1:0]   o_blt_valid,
   output logic [SLOTS*X_W-1:0] o_blt_x,
   output logic [SLOTS*Y_W-1:0] o_blt_y
);

   state_t           state;
   state_t           state_nxt;
   logic             step;
   logic             check;
   logic             accept;
   logic             found;
   logic [SLOTS-1:0] occ;
   logic [SLOTS-1:0] hit_vec;
   logic [SLOTS-1:0] free_onehot;
   logic [SLOTS-1:0] load_vec;
   logic [SLOTS-1:0] clear_vec;
   logic [7:0]       hit_cnt;
   logic [7:0]       damage;
   logic [HP_W-1:0]  hp;
   logic [HP_W-1:0]  hp_after;
   logic             hit_q;
   bullet_t          blt [SLOTS];

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [7:0]      d);
      if ({1'b0, a} <= d) return '0;
      return a - d[HP_W-1:0];
   endfunction

   assign o_fire_ready = (state != KO) && !(&occ);
   assign accept       = i_fire_valid && o_fire_ready && !i_round_start;

   always_comb begin
      free_onehot = '0;
      found       = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!occ[i] && !found) begin
            free_onehot[i] = 1'b1;
            found          = 1'b1;
         end
      end
      load_vec = accept ? free_onehot : '0;
   end

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < SLOTS; i++) begin
         hit_cnt = hit_cnt + 8'(hit_vec[i]);
      end
      damage   = hit_cnt * 8'(DAMAGE);
      hp_after = sat_sub(hp, damage);
   end

   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      check     = 1'b0;
      case (state)
         IDLE: begin
            if (hp == '0)   state_nxt = KO;
            else if (i_frame) state_nxt = STEP;
         end
         STEP: begin
            step      = 1'b1;
            state_nxt = CHECK;
         end
         CHECK: begin
            check     = 1'b1;
            state_nxt = (hp_after == '0) ? KO : IDLE;
         end
         KO: begin
            step = i_frame;
         end
         default: state_nxt = IDLE;
      endcase
      // A new round overrides any frame work scheduled for this cycle.
      if (i_round_start) begin
         state_nxt = IDLE;
         step      = 1'b0;
         check     = 1'b0;
      end
   end

   assign clear_vec = i_round_start ? '1 : (check ? hit_vec : '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         hp    <= HP_W'(MAX_HP);
         hit_q <= 1'b0;
      end else begin
         state <= state_nxt;
         hit_q <= check && (|hit_vec);
         if (i_round_start)  hp <= HP_W'(MAX_HP);
         else if (check)     hp <= hp_after;
      end
   end

   assign o_hp  = hp;
   assign o_hit = hit_q;
   assign o_ko  = (state == KO);

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      bullet_slot #(
         .X_W (X_W),
         .Y_W (Y_W)
      ) u_slot (
         .clk      (i_clk),
         .rst_n    (i_rst_n),
         .load     (load_vec[i]),
         .load_x   (i_fire_x),
         .load_y   (i_fire_y),
         .load_dir (i_fire_dir),
         .step     (step),
         .clear    (clear_vec[i]),
         .tgt_x    (i_tgt_x),
         .tgt_y    (i_tgt_y),
         .blt      (blt[i]),
         .hit      (hit_vec[i])
      );
      assign occ[i]                   = blt[i].valid;
      assign o_blt_valid[i]           = blt[i].valid;
      assign o_blt_x[i*X_W +: X_W]    = blt[i].x;
      assign o_blt_y[i*Y_W +: Y_W]    = blt[i].y;
   end

endmodule
